// File: rtl/cmac_pkt_pkg.sv
// Shared definitions for the CMAC 100G AXIS packet generator and monitor:
// beat geometry, FSM state codes and the payload pattern helpers.
package cmac_pkt_pkg;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned OFFSET_W   = 14;
  localparam int unsigned DATA_W     = 8 * BEAT_BYTES;
  localparam int unsigned SEQ_W      = 8;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] S_WAIT_ALIGN = 2'd0;
  localparam logic [STATE_W-1:0] S_ARMED      = 2'd1;
  localparam logic [STATE_W-1:0] S_IN_PKT     = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE       = 2'd3;

  // Contiguous tkeep of the final beat for a frame of len bytes
  function automatic logic [BEAT_BYTES-1:0] last_keep(input logic [OFFSET_W-1:0] len);
    int unsigned rem;
    rem = 32'(len) % BEAT_BYTES;
    if (rem == 0) return '1;
    return (BEAT_BYTES'(1) << rem) - BEAT_BYTES'(1);
  endfunction

  // Payload byte at a given frame offset for sequence number seq
  function automatic logic [7:0] exp_byte(input logic [OFFSET_W-1:0] offset,
                                          input logic [SEQ_W-1:0]    seq);
    return 8'(offset + OFFSET_W'(seq));
  endfunction

endpackage

// File: rtl/cmac_pkt_pattern_chk.sv
// 64-lane payload comparator: flags, one cycle after the beat, whether any
// kept byte differs from the generator pattern.
module cmac_pkt_pattern_chk
  import cmac_pkt_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [BEAT_BYTES-1:0] keep_i,
  input  logic [OFFSET_W-1:0]   base_i,
  input  logic [SEQ_W-1:0]      seq_i,
  output logic                  mism_o
);

  logic [BEAT_BYTES-1:0] lane_mis_c;
  logic                  mism_d;
  logic                  mism_q;

  always_comb begin
    lane_mis_c = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      lane_mis_c[k] = keep_i[k] &&
                      (data_i[8*k +: 8] != exp_byte(base_i + OFFSET_W'(k), seq_i));
    end
    mism_d = vld_i && (|lane_mis_c);
  end

  always_ff @(posedge clk) begin
    if (reset) mism_q <= 1'b0;
    else       mism_q <= mism_d;
  end

  assign mism_o = mism_q;

endmodule

// File: rtl/cmac_usplus_0_axis_pkt_mon.sv
// RX AXIS packet monitor for the CMAC 100G loopback: checks frame length,
// tkeep shape, tuser and payload pattern, and counts good/bad frames.
module cmac_usplus_0_axis_pkt_mon
  import cmac_pkt_pkg::*;
#(
  parameter int unsigned PKT_NUM  = 1000,
  parameter int unsigned PKT_SIZE = 522
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stat_rx_aligned,
  input  logic                  rx_axis_tvalid,
  input  logic [DATA_W-1:0]     rx_axis_tdata,
  input  logic [BEAT_BYTES-1:0] rx_axis_tkeep,
  input  logic                  rx_axis_tlast,
  input  logic                  rx_axis_tuser,
  output logic                  rx_aligned_led,
  output logic                  rx_busy_led,
  output logic                  rx_done_led,
  output logic                  rx_data_fail_led,
  output logic [CNT_W-1:0]      rx_pkt_cnt,
  output logic [CNT_W-1:0]      rx_err_cnt
);

  localparam int unsigned LAST_BYTES =
    ((PKT_SIZE % BEAT_BYTES) == 0) ? BEAT_BYTES : (PKT_SIZE % BEAT_BYTES);
  localparam logic [OFFSET_W-1:0]   LAST_BASE  = OFFSET_W'(PKT_SIZE - LAST_BYTES);
  localparam logic [BEAT_BYTES-1:0] LAST_KEEP  = last_keep(OFFSET_W'(PKT_SIZE));
  localparam logic [CNT_W:0]        NUM_TARGET = (CNT_W+1)'(PKT_NUM);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic                ovf_q, ovf_d;
  logic                serr_q, serr_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                fin_q, fin_d;
  logic                fin_bad_q, fin_bad_d;
  logic                pat_acc_q, pat_acc_d;
  logic [CNT_W-1:0]    pkt_q, pkt_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                fail_q, fail_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                aligned_q;

  logic                acc_c, last_c, abort_c, beat_bad_c, frame_bad_c, hit_c;
  logic [OFFSET_W:0]   off_sum_c;
  logic                mism;

  cmac_pkt_pattern_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (acc_c),
    .data_i (rx_axis_tdata),
    .keep_i (rx_axis_tkeep),
    .base_i (off_q),
    .seq_i  (seq_q),
    .mism_o (mism)
  );

  // Beat acceptance, frame tracking and the count stage one cycle behind
  always_comb begin
    acc_c = rx_axis_tvalid &&
            ((state_q == S_DONE) ||
             ((state_q == S_ARMED) && stat_rx_aligned) ||
             ((state_q == S_IN_PKT) && (stat_rx_aligned || rx_axis_tlast)));
    last_c  = acc_c && rx_axis_tlast;
    abort_c = (state_q == S_IN_PKT) && !stat_rx_aligned &&
              !(rx_axis_tvalid && rx_axis_tlast);

    if (rx_axis_tlast) begin
      beat_bad_c = (rx_axis_tkeep != LAST_KEEP) || (off_q != LAST_BASE) ||
                   ovf_q || rx_axis_tuser;
    end else begin
      beat_bad_c = (rx_axis_tkeep != {BEAT_BYTES{1'b1}});
    end

    off_sum_c = {1'b0, off_q} + (OFFSET_W+1)'(BEAT_BYTES);

    off_d  = off_q;
    ovf_d  = ovf_q;
    serr_d = serr_q;
    if (last_c || abort_c) begin
      off_d  = '0;
      ovf_d  = 1'b0;
      serr_d = 1'b0;
    end else if (acc_c) begin
      if (off_sum_c[OFFSET_W]) begin
        off_d = '1;
        ovf_d = 1'b1;
      end else begin
        off_d = off_sum_c[OFFSET_W-1:0];
      end
      serr_d = serr_q || beat_bad_c;
    end

    fin_d     = last_c || abort_c;
    fin_bad_d = abort_c || (last_c && (serr_q || beat_bad_c));
    seq_d     = fin_d ? (seq_q + SEQ_W'(1)) : seq_q;

    // The pattern verdict of the tlast beat arrives together with fin_q
    frame_bad_c = fin_bad_q || pat_acc_q || mism;
    pat_acc_d   = fin_q ? 1'b0 : (pat_acc_q || mism);

    pkt_d  = pkt_q;
    err_d  = err_q;
    fail_d = fail_q;
    hit_c  = 1'b0;
    if (fin_q) begin
      if (pkt_q != {CNT_W{1'b1}}) begin
        pkt_d = pkt_q + CNT_W'(1);
        hit_c = (({1'b0, pkt_q} + (CNT_W+1)'(1)) == NUM_TARGET);
      end
      if (frame_bad_c) begin
        fail_d = 1'b1;
        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_ALIGN: if (stat_rx_aligned) state_d = S_ARMED;
      S_ARMED: begin
        if (!stat_rx_aligned)                         state_d = S_WAIT_ALIGN;
        else if (rx_axis_tvalid && !rx_axis_tlast)    state_d = S_IN_PKT;
      end
      S_IN_PKT: begin
        if (rx_axis_tvalid && rx_axis_tlast)
          state_d = stat_rx_aligned ? S_ARMED : S_WAIT_ALIGN;
        else if (!stat_rx_aligned)
          state_d = S_WAIT_ALIGN;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WAIT_ALIGN;
    endcase
    if (hit_c) state_d = S_DONE;

    busy_d = (state_d == S_ARMED) || (state_d == S_IN_PKT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT_ALIGN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q     <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
      seq_q     <= '0;
      fin_q     <= 1'b0;
      fin_bad_q <= 1'b0;
      pat_acc_q <= 1'b0;
      pkt_q     <= '0;
      err_q     <= '0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      off_q     <= off_d;
      ovf_q     <= ovf_d;
      serr_q    <= serr_d;
      seq_q     <= seq_d;
      fin_q     <= fin_d;
      fin_bad_q <= fin_bad_d;
      pat_acc_q <= pat_acc_d;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      aligned_q <= stat_rx_aligned;
    end
  end

  assign rx_aligned_led   = aligned_q;
  assign rx_busy_led      = busy_q;
  assign rx_done_led      = done_q;
  assign rx_data_fail_led = fail_q;
  assign rx_pkt_cnt       = pkt_q;
  assign rx_err_cnt       = err_q;

endmodule

// File: tb/tb_cmac_usplus_0_axis_pkt_mon.sv
// Directed bench for the CMAC RX packet monitor: frames are generated from the
// (offset + seq) pattern and every counter update is scored against a queue.
module tb_cmac_usplus_0_axis_pkt_mon;

  localparam int unsigned A_NUM  = 1000;
  localparam int unsigned A_SIZE = 522;
  localparam int unsigned B_NUM  = 50;
  localparam int unsigned B_SIZE = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         aligned;
  logic         tvalid;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tuser;
  logic         use_b;

  logic        a_valid, b_valid;
  logic        a_al, a_busy, a_done, a_fail;
  logic [15:0] a_pkt, a_err;
  logic        b_al, b_busy, b_done, b_fail;
  logic [15:0] b_pkt, b_err;
  logic        c_al, c_busy, c_done, c_fail;
  logic [15:0] c_pkt, c_err;

  always #5 clk = ~clk;

  assign a_valid = tvalid & ~use_b;
  assign b_valid = tvalid & use_b;
  assign c_al    = use_b ? b_al   : a_al;
  assign c_busy  = use_b ? b_busy : a_busy;
  assign c_done  = use_b ? b_done : a_done;
  assign c_fail  = use_b ? b_fail : a_fail;
  assign c_pkt   = use_b ? b_pkt  : a_pkt;
  assign c_err   = use_b ? b_err  : a_err;

  cmac_usplus_0_axis_pkt_mon #(.PKT_NUM(A_NUM), .PKT_SIZE(A_SIZE)) u_dut_a (
    .clk(clk), .reset(reset), .stat_rx_aligned(aligned),
    .rx_axis_tvalid(a_valid), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .rx_aligned_led(a_al), .rx_busy_led(a_busy), .rx_done_led(a_done),
    .rx_data_fail_led(a_fail), .rx_pkt_cnt(a_pkt), .rx_err_cnt(a_err)
  );

  cmac_usplus_0_axis_pkt_mon #(.PKT_NUM(B_NUM), .PKT_SIZE(B_SIZE)) u_dut_b (
    .clk(clk), .reset(reset), .stat_rx_aligned(aligned),
    .rx_axis_tvalid(b_valid), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .rx_aligned_led(b_al), .rx_busy_led(b_busy), .rx_done_led(b_done),
    .rx_data_fail_led(b_fail), .rx_pkt_cnt(b_pkt), .rx_err_cnt(b_err)
  );

  typedef struct {
    int due;
    int pkt;
    int err;
    bit fail;
    bit done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;
  int   exp_pkt, exp_err, seq;
  bit   exp_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    tkeep  = '0;
    tdata  = '0;
  endtask

  task automatic model_clear();
    exp_pkt  = 0;
    exp_err  = 0;
    exp_fail = 1'b0;
    seq      = 0;
  endtask

  // Record the expected counter state for a completed (or aborted) frame
  task automatic push(input bit bad);
    exp_t e;
    int   num;
    num = use_b ? B_NUM : A_NUM;
    exp_pkt++;
    if (bad) begin
      exp_err++;
      exp_fail = 1'b1;
    end
    e.due  = ncyc + 3;
    e.pkt  = exp_pkt;
    e.err  = exp_err;
    e.fail = exp_fail;
    e.done = (exp_pkt >= num);
    q.push_back(e);
    seq++;
  endtask

  task automatic send_frame(input int len, input int corrupt, input bit usr,
                            input logic [63:0] keep_ovr, input int gap, input int cut);
    int         nb, rem, sz;
    bit         bad;
    logic [7:0] bv;
    sz  = use_b ? B_SIZE : A_SIZE;
    nb  = (len + 63) / 64;
    bad = (len != sz) || (corrupt >= 0) || usr || (keep_ovr != 64'd0);
    for (int b = 0; b < nb; b++) begin
      if (cut >= 0 && b == cut) return;
      @(posedge clk); #1;
      tvalid = 1'b1;
      for (int l = 0; l < 64; l++) begin
        bv = 8'((b * 64 + l + seq) % 256);
        if (b * 64 + l == corrupt) bv = bv ^ 8'hA5;
        tdata[8*l +: 8] = bv;
      end
      tlast = (b == nb - 1);
      if (tlast) begin
        rem   = len - b * 64;
        tkeep = (rem == 64) ? {64{1'b1}} : ((64'd1 << rem) - 64'd1);
        if (keep_ovr != 64'd0) tkeep = keep_ovr;
        tuser = usr;
        push(bad);
      end else begin
        tkeep = {64{1'b1}};
        tuser = 1'b0;
      end
    end
    if (gap > 0) begin
      @(posedge clk); #1;
      idle();
      repeat (gap - 1) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
  endtask

  task automatic final_checks(input string tag, input int pkt, input int err, input bit fail);
    repeat (6) @(negedge clk);
    check({tag, "_pkt"},  32'(c_pkt),  pkt);
    check({tag, "_err"},  32'(c_err),  err);
    check({tag, "_done"}, 32'(c_done), 1);
    check({tag, "_busy"}, 32'(c_busy), 0);
    check({tag, "_fail"}, 32'(c_fail), 32'(fail));
    check({tag, "_queue"}, q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    aligned = 1'b0;
    use_b = 1'b1;
    idle();
    model_clear();

    // Scoreboard: every counter change pops the oldest expectation
    fork
      begin : monitor
        exp_t        e;
        logic [15:0] prev;
        prev = '0;
        forever begin
          @(negedge clk);
          ncyc++;
          if (reset) begin
            prev = '0;
          end else if (c_pkt !== prev) begin
            check("update_expected", (q.size() > 0), 1);
            if (q.size() > 0) begin
              e = q.pop_front();
              check("update_cycle", ncyc, e.due);
              check("pkt_cnt", 32'(c_pkt), e.pkt);
              check("err_cnt", 32'(c_err), e.err);
              check("fail_led", 32'(c_fail), 32'(e.fail));
              check("done_led", 32'(c_done), 32'(e.done));
            end
            prev = c_pkt;
          end else if (q.size() > 0 && ncyc > q[0].due) begin
            e = q.pop_front();
            check("update_late", 32'(c_pkt), e.pkt);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_b_pkt",  32'(b_pkt),  0);
    check("rst_b_err",  32'(b_err),  0);
    check("rst_b_done", 32'(b_done), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    check("rst_b_fail", 32'(b_fail), 0);
    check("rst_a_pkt",  32'(a_pkt),  0);
    @(posedge clk); #1 reset = 1'b0;

    // Alignment LED lags by one cycle; busy follows entry to the armed state
    @(posedge clk); #1 aligned = 1'b1;
    @(negedge clk);
    check("aligned_lag0", 32'(c_al),   0);
    check("busy_wait",    32'(c_busy), 0);
    @(negedge clk);
    check("aligned_lag1", 32'(c_al),   1);
    check("busy_armed",   32'(c_busy), 1);
    repeat (2) @(posedge clk);

    // Back-to-back single-beat 64 B frames
    for (int i = 0; i < int'(B_NUM); i++) send_frame(64, -1, 1'b0, 64'd0, 0, -1);
    @(posedge clk); #1 idle();
    final_checks("b2b", B_NUM, 0, 1'b0);

    // Clean run of 522 B frames with 2-cycle gaps, then one frame past done
    use_b = 1'b0;
    do_reset();
    for (int i = 0; i < int'(A_NUM); i++) send_frame(522, -1, 1'b0, 64'd0, 2, -1);
    final_checks("clean", A_NUM, 0, 1'b0);
    send_frame(522, -1, 1'b0, 64'd0, 2, -1);
    final_checks("post_done", A_NUM + 1, 0, 1'b0);

    // Reset in the middle of frame 10
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(522, -1, 1'b0, 64'd0, 2, -1);
    send_frame(522, -1, 1'b0, 64'd0, 0, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_pkt",  32'(c_pkt),  0);
    check("midrst_err",  32'(c_err),  0);
    check("midrst_fail", 32'(c_fail), 0);
    check("midrst_done", 32'(c_done), 0);
    check("midrst_busy", 32'(c_busy), 0);
    check("midrst_al",   32'(c_al),   0);
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);

    // Full run from zero with corrupt, short, tuser, bad-keep and aborted frames
    for (int i = 0; i < int'(A_NUM); i++) begin
      case (i)
        5:  send_frame(522, 100, 1'b0, 64'd0, 2, -1);
        10: send_frame(521, -1, 1'b0, 64'd0, 2, -1);
        11: send_frame(522, -1, 1'b1, 64'd0, 2, -1);
        12: send_frame(522, -1, 1'b0, 64'h2FF, 2, -1);
        13: begin
          send_frame(522, -1, 1'b0, 64'd0, 0, 4);
          @(posedge clk); #1;
          idle();
          aligned = 1'b0;
          push(1'b1);
          repeat (3) @(negedge clk);
          check("unalign_busy", 32'(c_busy), 0);
          check("unalign_led",  32'(c_al),   0);
          @(posedge clk); #1 aligned = 1'b1;
          repeat (3) @(posedge clk);
        end
        default: send_frame(522, -1, 1'b0, 64'd0, 2, -1);
      endcase
    end
    final_checks("errors", A_NUM, 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
